pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Multi-cycle control FSM that sequences the program counter, instruction fetch, data memory and register-file writeback for the RV32 core. It drives the PC's `op`/`pc_src` controls with one increment or redirect per retired instruction. It handshakes with instruction and data memory, and halts on ECALL/EBREAK or on a bus timeout. It sits between the instruction register / ALU compare outputs and the PC, memory ports and register file.

Parameters:
TIMEOUT_CYCLES, 16, max consecutive wait cycles in FETCH or MEM before bus error (range 2..255)
CNT_W, 32, width of retired-instruction counter

Ports:
sys_clk  in  1  system clock; all state updates on rising edge
sys_rst  in  1  reset, asynchronous, active-low
run  in  1  1 = sequence instructions; 0 = park in IDLE at next instruction boundary
imem_req  out  1  instruction fetch request
imem_ready  in  1  fetch data valid this cycle
ir_load  out  1  one-cycle pulse, latch instruction into IR
opcode  in  7  IR[6:0]; sampled only in DECODE
branch_taken  in  1  ALU compare result; sampled only in EXEC
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1
dmem_ready  in  1  data access complete this cycle
rf_we  out  1  register-file write enable
pc_op  out  1  to PC `op`: one-cycle pulse per retired instruction
pc_src  out  1  to PC `pc_src`: 0 = sequential, 1 = ALU target; valid when pc_op=1
state  out  3  current state encoding (debug)
halted  out  1  1 while in HALT
bus_err  out  1  sticky; set on memory timeout
illegal_op  out  1  sticky; set on illegal opcode (see Optional Feature)
instret  out  CNT_W  retired-instruction count

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is unreachable and recovers to IDLE.
- Reset, while sys_rst=0 (asynchronous): state=IDLE, instret=0, bus_err=0, illegal_op=0, wait counter=0, latched class=NONE. All outputs are 0 immediately, including mid-transaction; no pulse completes.
- Control outputs are combinational from state, the latched opcode class, and the ready inputs. They are not registered.
- IDLE: run=1 -> FETCH next cycle.
- FETCH: imem_req=1.
  - imem_ready=1 -> ir_load=1 in the same cycle; -> DECODE.
  - Otherwise wait counter increments; when it reaches TIMEOUT_CYCLES-1 with no ready -> HALT and set bus_err.
  - run is ignored while in FETCH.
- DECODE: latch opcode class; -> EXEC. Classes:
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011
  - JAL 1101111
  - JALR 1100111
  - ALU: 0110011, 0010011, 0110111, 0010111
  - SYS 1110011
  - FENCE 0001111 is treated as ALU without rf_we
  - Any other code is ILLEGAL
- EXEC:
  - BRANCH: pc_op=1, pc_src=branch_taken; retire.
  - LOAD/STORE -> MEM.
  - ALU/JAL/JALR -> WB.
  - SYS -> HALT; no pc_op, no retire.
- MEM: dmem_req=1; dmem_we=1 only for STORE.
  - On dmem_ready: LOAD -> WB; STORE asserts pc_op=1, pc_src=0, and retires.
  - Timeout behaves as in FETCH.
- WB: pc_op=1; pc_src=1 for JAL/JALR, else 0; rf_we=1 except FENCE; retire. The link value is sampled by the datapath from the pre-update next_pc.
- Retire: instret += 1 (wraps to 0 at 2^CNT_W). Next state is FETCH if run=1, else IDLE.
- Wait counter clears on every state change.
- HALT: all request/enable outputs are 0 and halted=1. HALT is sticky; only reset exits.
- pc_op is asserted exactly once per retired instruction and never in two consecutive cycles.

Optional Feature:
ILLEGAL_HALT_EN
- Defined: ILLEGAL class in EXEC -> HALT, illegal_op=1, no retire.
- Undefined: ILLEGAL class is treated as a NOP. It goes to WB with rf_we=0, pc_op=1, pc_src=0, and retires; illegal_op is tied to 0.

Test Plan:
1. Release reset, run=1, imem_ready after 2 wait cycles, opcode 0110011 -> state sequence 0,1,1,1,2,3,5. ir_load is a single pulse; in WB pc_op=1, pc_src=0, rf_we=1; instret=1; then state returns to FETCH.
2. Opcode 1100011 with branch_taken=1, then repeated with branch_taken=0 -> pc_op pulses in EXEC with pc_src=1 and 0 respectively. rf_we stays 0; instret increments by 2 total.
3. Load (0000011) with dmem_ready delayed 3 cycles -> 4 MEM cycles with dmem_req=1, dmem_we=0, then WB rf_we=1. Store (0100011) -> dmem_we=1, pc_op fires in MEM, WB is skipped.
4. TIMEOUT_CYCLES=16, imem_ready held 0 -> after 16 FETCH cycles state=6, bus_err=1, halted=1. instret is unchanged; run toggling has no effect until reset.
5. Opcode 1110011 -> HALT from EXEC, no pc_op pulse. Opcode 1111111 -> with ILLEGAL_HALT_EN: HALT and illegal_op=1; without: retire with rf_we=0 and instret+1.
6. Assert sys_rst=0 mid-MEM with dmem_req=1 -> all outputs drop to 0 without a clock edge. state=0, instret=0; after release with run=0, the block stays in IDLE.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control FSM for the RV32 core. Sequences fetch,
// decode, execute, data-memory access and writeback, issuing exactly one PC
// update (pc_op) per retired instruction. It halts on ECALL/EBREAK and on a
// bus timeout.
//
// Ports:
//   sys_clk, sys_rst          clock; asynchronous active-low reset
//   run                       1 = keep sequencing; 0 = park in IDLE at retire
//   imem_req/imem_ready       instruction fetch handshake
//   ir_load                   latch the instruction into the IR (same cycle as imem_ready)
//   opcode                    IR[6:0], sampled in DECODE
//   branch_taken              ALU compare result, sampled in EXEC
//   dmem_req/dmem_we/dmem_ready  data memory handshake
//   rf_we                     register-file write enable
//   pc_op, pc_src             PC update strobe and source select
//   state, halted             debug state code; HALT indicator
//   bus_err, illegal_op       sticky error flags
//   instret                   retired-instruction counter
//
// Build option: define ILLEGAL_HALT_EN so that an illegal opcode halts and
// sets illegal_op. Without it, an illegal opcode retires as a NOP.
module pc_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_load,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             rf_we,
  output logic             pc_op,
  output logic             pc_src,
  output logic [2:0]       state,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR,
    C_ALU, C_SYS, C_FENCE, C_ILLEGAL
  } class_e;

  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e           r_state;
  class_e           r_class;
  logic [7:0]       r_wait;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_instret;
  class_e           w_class;
  state_e           w_after_retire;

`ifdef ILLEGAL_HALT_EN
  logic r_illegal;
  assign illegal_op = r_illegal;
`else
  assign illegal_op = 1'b0;
`endif

  assign state   = r_state;
  assign bus_err = r_bus_err;
  assign instret = r_instret;
  assign halted  = (r_state == S_HALT);

  assign w_after_retire = run ? S_FETCH : S_IDLE;

  always_comb begin
    w_class = C_ILLEGAL;
    case (opcode)
      7'b0000011: w_class = C_LOAD;
      7'b0100011: w_class = C_STORE;
      7'b1100011: w_class = C_BRANCH;
      7'b1101111: w_class = C_JAL;
      7'b1100111: w_class = C_JALR;
      7'b0110011, 7'b0010011,
      7'b0110111, 7'b0010111: w_class = C_ALU;
      7'b1110011: w_class = C_SYS;
      7'b0001111: w_class = C_FENCE;
      default:    w_class = C_ILLEGAL;
    endcase
  end

  // Controls are decoded from state and the latched class; pc_op doubles as
  // the retire strobe so the counter and the PC can never disagree.
  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_op    = 1'b0;
    pc_src   = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      S_EXEC: begin
        if (r_class == C_BRANCH) begin
          pc_op  = 1'b1;
          pc_src = branch_taken;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (r_class == C_STORE);
        pc_op    = (r_class == C_STORE) && dmem_ready;
      end
      S_WB: begin
        pc_op  = 1'b1;
        pc_src = (r_class == C_JAL) || (r_class == C_JALR);
        rf_we  = (r_class != C_FENCE) && (r_class != C_ILLEGAL);
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state   <= S_IDLE;
      r_class   <= C_NONE;
      r_wait    <= '0;
      r_bus_err <= 1'b0;
      r_instret <= '0;
`ifdef ILLEGAL_HALT_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      // Only the wait branches below keep counting; any other path,
      // including every state change, clears the counter.
      r_wait <= '0;
      case (r_state)
        S_IDLE: if (run) r_state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            r_state <= S_DECODE;
          end else if (r_wait == LP_WAIT_LAST) begin
            r_state   <= S_HALT;
            r_bus_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_DECODE: begin
          r_class <= w_class;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          case (r_class)
            C_BRANCH:         r_state <= w_after_retire;
            C_LOAD, C_STORE:  r_state <= S_MEM;
            C_SYS:            r_state <= S_HALT;
            C_ILLEGAL: begin
`ifdef ILLEGAL_HALT_EN
              r_state   <= S_HALT;
              r_illegal <= 1'b1;
`else
              r_state <= S_WB;
`endif
            end
            default:          r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            r_state <= (r_class == C_STORE) ? w_after_retire : S_WB;
          end else if (r_wait == LP_WAIT_LAST) begin
            r_state   <= S_HALT;
            r_bus_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_WB:    r_state <= w_after_retire;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
      if (pc_op) r_instret <= r_instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          run = 1'b0;
  logic          imem_ready = 1'b0;
  logic          dmem_ready = 1'b0;
  logic          branch_taken = 1'b0;
  logic [6:0]    opcode = '0;
  logic          imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_op, pc_src;
  logic          halted, bus_err, illegal_op;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  pc_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .run(run),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_load(ir_load),
    .opcode(opcode), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .pc_op(pc_op), .pc_src(pc_src), .state(state),
    .halted(halted), .bus_err(bus_err), .illegal_op(illegal_op),
    .instret(instret)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          src;
    bit          we;
    int unsigned idx;
  } exp_t;

  exp_t        sb_q[$];
  bit          mem_q[$];
  int unsigned model_cnt = 0;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one instruction, straight from the opcode table.
  function automatic void model(input logic [6:0] op, input bit bt,
                                output bit ret, output bit src, output bit we,
                                output bit mem, output bit st);
    ret = 1'b1; src = 1'b0; we = 1'b0; mem = 1'b0; st = 1'b0;
    case (op)
      7'b0000011: begin we = 1'b1; mem = 1'b1; end
      7'b0100011: begin mem = 1'b1; st = 1'b1; end
      7'b1100011: src = bt;
      7'b1101111, 7'b1100111: begin src = 1'b1; we = 1'b1; end
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: we = 1'b1;
      7'b0001111: ;
      7'b1110011: ret = 1'b0;
      default: begin
`ifdef ILLEGAL_HALT_EN
        ret = 1'b0;
`endif
      end
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever the DUT retires or completes a data access.
  bit          prev_op = 1'b0;
  bit          pend_nx = 1'b0;
  int unsigned exp_nx = 0;

  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst) begin
      prev_op = 1'b0;
      pend_nx = 1'b0;
    end else begin
      if (pend_nx) begin
        check("next_state_after_retire", 32'(state), exp_nx);
        pend_nx = 1'b0;
      end
      if (imem_req) check("ir_load_follows_ready", 32'(ir_load), 32'(imem_ready));
      if (pc_op) begin
        check("pc_op_gap", 32'(prev_op), 32'd0);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL pc_op_unexpected: got pc_op=1 expected no retire at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("pc_src", 32'(pc_src), 32'(e.src));
          check("rf_we", 32'(rf_we), 32'(e.we));
          check("instret_at_retire", instret, e.idx);
        end
        pend_nx = 1'b1;
        exp_nx  = run ? 1 : 0;
      end else if (rf_we) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rf_we_stray: got rf_we=1 expected 0 without pc_op at %0t", $time);
      end
      if (dmem_req && dmem_ready) begin
        if (mem_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL dmem_unexpected: got dmem access expected none at %0t", $time);
        end else begin
          check("dmem_we", 32'(dmem_we), 32'(mem_q.pop_front()));
        end
      end
      prev_op = pc_op;
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout expected handshake at %0t", name, $time);
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        return;
      end
      if (state == 3'd0) run = 1'b1;
      step();
    end
    bound_fail("wait_imem_req");
  endtask

  task automatic wait_dmem(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (dmem_req) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    bound_fail("wait_dmem_req");
  endtask

  task automatic issue(input logic [6:0] op, input bit bt,
                       input int unsigned fd, input int unsigned md);
    bit ok, ret, src, we, mem, st;
    model(op, bt, ret, src, we, mem, st);
    wait_fetch(ok);
    if (!ok) return;
    repeat (fd) step();
    imem_ready   = 1'b1;
    opcode       = op;
    branch_taken = bt;
    if (ret) begin
      sb_q.push_back('{src: src, we: we, idx: model_cnt});
      model_cnt++;
    end
    if (mem) mem_q.push_back(st);
    step();
    imem_ready = 1'b0;
    run = ($urandom_range(0, 3) != 0);
    if (mem) begin
      wait_dmem(ok);
      if (!ok) return;
      repeat (md) step();
      dmem_ready = 1'b1;
      step();
      dmem_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    sys_rst    = 1'b0;
    run        = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    sb_q.delete();
    mem_q.delete();
    model_cnt  = 0;
    step();
    step();
    sys_rst = 1'b1;
  endtask

  logic [6:0] ops [10];

  initial begin
    bit ok;
    int unsigned cnt;
    ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0001111};

    // Reset state, held and after release with run=0
    step();
    check("reset_outputs", 32'({imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_op,
                                pc_src, state, halted, bus_err, illegal_op}), 32'd0);
    check("reset_instret", instret, 32'd0);
    sys_rst = 1'b1;
    repeat (3) step();
    check("idle_without_run", 32'(state), 32'd0);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      issue(ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)),
            $urandom_range(0, 5), $urandom_range(0, 5));
    end
    run = 1'b0;
    repeat (6) step();
    check("stream_drained", sb_q.size(), 32'd0);
    check("stream_instret", instret, model_cnt);
    check("stream_no_bus_err", 32'(bus_err), 32'd0);

    // Fetch timeout
    do_reset();
    run = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (halted) break;
      if (imem_req) cnt++;
      step();
    end
    check("timeout_fetch_cycles", cnt, TO);
    check("timeout_state", 32'(state), 32'd6);
    check("timeout_bus_err", 32'(bus_err), 32'd1);
    check("timeout_instret", instret, 32'd0);
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      step();
    end
    check("halt_sticky", 32'(state), 32'd6);
    check("halt_no_req", 32'({imem_req, dmem_req, rf_we, pc_op}), 32'd0);

    // SYS halts from EXEC without a retire
    do_reset();
    issue(7'b0110011, 1'b0, 2, 0);
    issue(7'b1110011, 1'b0, 0, 0);
    repeat (4) step();
    check("sys_halted", 32'(halted), 32'd1);
    check("sys_instret", instret, 32'd1);
    check("sys_bus_err", 32'(bus_err), 32'd0);
    check("sys_drained", sb_q.size(), 32'd0);

    // Illegal opcode
    do_reset();
    issue(7'b1111111, 1'b0, 1, 0);
    run = 1'b0;
    repeat (4) step();
`ifdef ILLEGAL_HALT_EN
    check("illegal_halted", 32'(halted), 32'd1);
    check("illegal_flag", 32'(illegal_op), 32'd1);
    check("illegal_instret", instret, 32'd0);
`else
    check("illegal_not_halted", 32'(halted), 32'd0);
    check("illegal_flag", 32'(illegal_op), 32'd0);
    check("illegal_instret", instret, 32'd1);
`endif
    check("illegal_drained", sb_q.size(), 32'd0);

    // Asynchronous reset in the middle of a load
    do_reset();
    issue(7'b0010011, 1'b0, 0, 0);
    wait_fetch(ok);
    imem_ready = 1'b1;
    opcode     = 7'b0000011;
    step();
    imem_ready = 1'b0;
    wait_dmem(ok);
    step();
    check("mid_mem_req", 32'(dmem_req), 32'd1);
    check("mid_mem_instret", instret, 32'd1);
    #2;
    sys_rst = 1'b0;
    run     = 1'b0;
    #1;
    check("async_reset_outputs", 32'({imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_op,
                                      pc_src, state, halted, bus_err, illegal_op}), 32'd0);
    check("async_reset_instret", instret, 32'd0);
    sb_q.delete();
    mem_q.delete();
    step();
    sys_rst = 1'b1;
    repeat (5) step();
    check("post_reset_idle", 32'(state), 32'd0);
    check("post_reset_no_fetch", 32'(imem_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
